// File: rtl/divider_pkg.sv
// divider_pkg: shared FSM state type and counter-width helper for divider_core
package divider_pkg;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} divider_state_t;
   localparam int DIV_N  = 8;
   localparam int DIV_CW = $clog2(DIV_N + 1);
   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction
endpackage

// File: rtl/divider_step.sv
// divider_step: one combinational restoring-division step
// ports: rem (N+1-bit partial remainder), quo (quotient shift reg), div (divisor) -> nrem, nquo
module divider_step #(
   parameter int N = 8
) (
   input  logic [N:0]   rem,
   input  logic [N-1:0] quo,
   input  logic [N-1:0] div,
   output logic [N:0]   nrem,
   output logic [N-1:0] nquo
);
   logic [N+1:0] s;
   logic [N:0]   d;
   logic         ge;
   always_comb begin
      s    = {rem, quo[N-1]};
      ge   = s >= {2'b00, div};
      d    = s[N:0] - {1'b0, div};
      nrem = ge ? d : s[N:0];
      nquo = {quo[N-2:0], ge};
   end
endmodule

// File: rtl/divider_core.sv
// divider_core: sequential unsigned restoring divider, one quotient bit per clock
// ports: clk, reset (async, active-high), start, dividend, divisor -> result, done
// optional: DIVIDER_REMAINDER_EN adds remainder output (dividend mod divisor)
module divider_core
   import divider_pkg::*;
#(
   parameter int N            = DIV_N,
   parameter bit verbose_flag = 1'b0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   output logic [N-1:0] result,
   output logic         done
`ifdef DIVIDER_REMAINDER_EN
   ,
   output logic [N-1:0] remainder
`endif
);
   localparam int CW = cnt_w(N);
   divider_state_t state;
   logic [N:0]    rem, nrem;
   logic [N-1:0]  quo, nquo, div;
   logic [CW-1:0] cnt;
   divider_step #(.N(N)) u_step (
      .rem  (rem),
      .quo  (quo),
      .div  (div),
      .nrem (nrem),
      .nquo (nquo)
   );
   if (verbose_flag) begin : g_verbose
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         result <= '0;
         done   <= 1'b0;
         rem    <= '0;
         quo    <= '0;
         div    <= '0;
         cnt    <= '0;
`ifdef DIVIDER_REMAINDER_EN
         remainder <= '0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               rem   <= '0;
               quo   <= dividend;
               div   <= divisor;
               cnt   <= CW'(N);
               state <= BUSY;
            end
            BUSY: begin
               rem   <= nrem;
               quo   <= nquo;
               cnt   <= cnt - CW'(1);
               state <= cnt == CW'(1) ? DONE : BUSY;
            end
            DONE: begin
               result <= quo;
               done   <= 1'b1;
               state  <= IDLE;
`ifdef DIVIDER_REMAINDER_EN
               remainder <= rem[N-1:0];
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_divider_core.sv
// tb_divider_core: directed and swept checks of divider_core against a quotient model
module tb_divider_core;
   localparam int N = 8;
   logic clk = 1'b0, reset = 1'b1, start = 1'b0, done;
   logic [N-1:0] dividend = '0, divisor = '0, result;
`ifdef DIVIDER_REMAINDER_EN
   logic [N-1:0] remainder;
   int m_r = 0, m_rem = 0;
`endif
   int total = 0, bad = 0, cyc = 0;
   bit pend = 0;
   int due = 0, m_q = 0, m_res = 0;

   divider_core #(.N(N), .verbose_flag(1'b0)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .dividend (dividend),
      .divisor  (divisor),
      .result   (result),
      .done     (done)
`ifdef DIVIDER_REMAINDER_EN
      ,
      .remainder(remainder)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      bit exp_d;
      exp_d = pend && cyc == due;
      chk("done", int'(done), int'(exp_d));
      if (exp_d) begin
         m_res = m_q;
`ifdef DIVIDER_REMAINDER_EN
         m_rem = m_r;
`endif
      end
      if (pend && cyc >= due) pend = 0;
      chk("result", int'(result), m_res);
`ifdef DIVIDER_REMAINDER_EN
      chk("remainder", int'(remainder), m_rem);
`endif
   end

   task automatic go(input int a, input int b);
      @(negedge clk);
      dividend = N'(a);
      divisor  = N'(b);
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      pend  = 1;
      due   = cyc + N + 1;
      m_q   = b == 0 ? (1 << N) - 1 : a / b;
`ifdef DIVIDER_REMAINDER_EN
      m_r   = b == 0 ? a : a % b;
`endif
   endtask

   task automatic wait_done();
      for (int i = 0; i < N + 10 && pend; i++) begin
         @(posedge clk);
         #2;
      end
      if (pend) begin
         chk("timeout", 1, 0);
         pend = 0;
      end
   endtask

   task automatic run(input string name, input int a, input int b, input int exp);
      go(a, b);
      wait_done();
      chk(name, int'(result), exp);
   endtask

   initial begin
      int da[8] = '{0, 1, 2, 127, 128, 200, 254, 255};
      repeat (3) @(negedge clk);
      chk("reset_result", int'(result), 0);
      chk("reset_done", int'(done), 0);
      #2 reset = 1'b0;
      repeat (4) @(negedge clk);
      run("200/7", 200, 7, 28);
      run("255/1", 255, 1, 255);
      run("5/9", 5, 9, 0);
      run("0/3", 0, 3, 0);
      run("255/255", 255, 255, 1);
      run("7/0", 7, 0, 255);
`ifdef DIVIDER_REMAINDER_EN
      chk("7/0_rem", int'(remainder), 7);
      run("200/7r", 200, 7, 28);
      chk("200/7_rem", int'(remainder), 4);
`endif
      go(100, 3);
      repeat (3) @(negedge clk);
      dividend = 8'd9;
      divisor  = 8'd3;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done();
      chk("busy_protect", int'(result), 33);
      go(50, 5);
      repeat (3) @(posedge clk);
      #3 reset = 1'b1;
      pend  = 0;
      m_res = 0;
`ifdef DIVIDER_REMAINDER_EN
      m_rem = 0;
`endif
      #1;
      chk("async_rst_result", int'(result), 0);
      chk("async_rst_done", int'(done), 0);
      repeat (2) @(negedge clk);
      #2 reset = 1'b0;
      repeat (N + 4) @(negedge clk);
      run("50/5", 50, 5, 10);
      foreach (da[i])
         for (int b = 0; b < 256; b++) begin
            go(da[i], b);
            wait_done();
         end
      for (int i = 0; i < 800; i++) begin
         go(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
         wait_done();
      end
      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
